// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory responder: FSM encoding, data
// widths and the request address check.
package mips_mem_pkg;

  localparam int DATA_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam int OFF_W      = $clog2(WORD_BYTES);
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // A request is in error when it is not word aligned or when any address
  // bit above the array's word index is set.
  function automatic logic addr_err(input logic [DATA_W-1:0] addr, input int aw);
    return (addr[OFF_W-1:0] != '0) || ((addr >> (aw + OFF_W)) != '0);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array: synchronous write, asynchronous read, no reset.
module mem_array
  import mips_mem_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // Store the write word on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory target for the multicycle MIPS core. Accepts one request at a
// time, waits WAIT_CYCLES cycles, then pulses rsp_valid for one cycle.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high; req_ready depends only on the FSM state. The
// response is a single-cycle rsp_valid strobe with no back-pressure; the
// rsp_rdata/rsp_err values are valid in that cycle and rsp_rdata holds
// until the next response.
module mem_responder
  import mips_mem_pkg::*;
#(
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wdata;
  logic                cur_write;
  logic                cur_err;
  logic                enter_resp;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DATA_W-1:0]   mem_rdata;

  // With zero wait states the transaction completes on the acceptance
  // edge, before the request is latched, so the live request is used in
  // IDLE and the latched copy otherwise.
  assign cur_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign cur_write = (state_q == ST_IDLE) ? req_write : write_q;
  assign cur_err   = addr_err(cur_addr, AW);
  assign mem_addr  = cur_addr[AW+OFF_W-1:OFF_W];

  mem_array #(
    .AW(AW)
  ) u_mem_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(cur_wdata),
    .rdata(mem_rdata)
  );

  // Next-state, wait counter, request latch and response data selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          cnt_d   = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        err_d     = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The write commits and the read data is captured on the same edge
    // that enters RESP; the array read is asynchronous so the capture sees
    // the word as it was before this edge.
    if (enter_resp) begin
      mem_we  = cur_write && !cur_err && rst_n;
      err_d   = cur_err;
      rdata_d = (cur_err || cur_write) ? '0 : mem_rdata;
    end
  end

  // State and response registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
